// File: rtl/spu_pkg.sv
// Shared SPU constants: GPR geometry, signal polarities and register-file FSM encoding.
package spu_pkg;

  localparam int SPU_DATA_W     = 128;
  localparam int SPU_GPR_NUM    = 128;
  localparam int SPU_GPR_ADDR_W = 7;

  localparam logic RST_ACT   = 1'b1;
  localparam logic WR_EN_ACT = 1'b1;
  localparam logic RD_EN_ACT = 1'b1;

  localparam logic [SPU_DATA_W-1:0] SPU_ZERO_W = '0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/spu_rf_rdport.sv
// One GPR read port: write-to-read bypass with highest-port priority and optional output register.
module spu_rf_rdport
  import spu_pkg::*;
#(
  parameter int DATA_W = SPU_DATA_W,
  parameter int ADDR_W = SPU_GPR_ADDR_W,
  parameter int NUM_WR = 2,
  parameter int RD_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     in_range,
  input  logic [DATA_W-1:0]        arr_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] rd_val;

  // Ascending scan so the highest matching write port overrides, mirroring the array write rule.
  always_comb begin
    rd_val = DATA_W'(SPU_ZERO_W);
    if (ready && (rd_en == RD_EN_ACT) && in_range) begin
      rd_val = arr_data;
      for (int i = 0; i < NUM_WR; i++) begin
        if ((wr_en[i] == WR_EN_ACT) && (wr_addr[i*ADDR_W +: ADDR_W] == rd_addr)) begin
          rd_val = wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  generate
    if (RD_REG != 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst == RST_ACT) begin
          rd_data <= DATA_W'(SPU_ZERO_W);
        end else begin
          rd_data <= rd_val;
        end
      end
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign rd_data = rd_val;
    end
  endgenerate

endmodule

// File: rtl/spu_regfile_mp.sv
// Parametrised multi-port SPU GPR array with post-reset clear sequencer, write-conflict flag and bypass.
module spu_regfile_mp
  import spu_pkg::*;
#(
  parameter int DATA_W      = SPU_DATA_W,
  parameter int DEPTH       = SPU_GPR_NUM,
  parameter int ADDR_W      = SPU_GPR_ADDR_W,
  parameter int NUM_WR      = 2,
  parameter int NUM_RD      = 6,
  parameter int RD_REG      = 0,
  parameter int CLR_PER_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     init_busy,
  output logic                     wr_conflict
);

  // state    | meaning
  // RF_CLEAR | sequencer zeroes CLR_PER_CYC entries per cycle; write/read ports ignored
  // RF_READY | normal operation: writes commit, reads/bypass active

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_STEP = ADDR_W'(CLR_PER_CYC);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - CLR_PER_CYC);

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic              ready;
  logic              conflict_nxt;
  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      state   <= RF_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == RF_CLEAR) begin
        clr_ptr <= clr_ptr + CLR_STEP;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    ready     = 1'b0;
    case (state)
      RF_CLEAR: begin
        init_busy = 1'b1;
        if (clr_ptr == CLR_LAST) state_nxt = RF_READY;
      end
      RF_READY: ready = 1'b1;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  // Ascending port order: on a shared address the highest port's data is the one that sticks.
  always_ff @(posedge clk) begin
    if (rst != RST_ACT) begin
      if (state == RF_CLEAR) begin
        for (int k = 0; k < CLR_PER_CYC; k++) begin
          regs[clr_ptr + ADDR_W'(k)] <= '0;
        end
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if ((wr_en[i] == WR_EN_ACT) &&
              ({1'b0, wr_addr[i*ADDR_W +: ADDR_W]} < DEPTH_L)) begin
            regs[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if ((wr_en[i] == WR_EN_ACT) && (wr_en[j] == WR_EN_ACT) &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
          conflict_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= ready & conflict_nxt;
    end
  end

  generate
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              in_range;
      logic [DATA_W-1:0] arr_q;

      assign addr     = rd_addr[j*ADDR_W +: ADDR_W];
      assign in_range = ({1'b0, addr} < DEPTH_L);
      assign arr_q    = in_range ? regs[addr] : '0;

      spu_rf_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR),
        .RD_REG (RD_REG)
      ) u_rdport (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .rd_en    (rd_en[j]),
        .rd_addr  (addr),
        .in_range (in_range),
        .arr_data (arr_q),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data[j*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_spu_regfile_mp.sv
// Bench for spu_regfile_mp: combinational and registered-read instances share one stimulus stream.
module tb_spu_regfile_mp;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   wr_en;
  logic [13:0]  wr_addr;
  logic [255:0] wr_data;
  logic [5:0]   rd_en;
  logic [41:0]  rd_addr;
  logic [767:0] rd_data0, rd_data1;
  logic         busy0, busy1, conf0, conf1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spu_regfile_mp #(.RD_REG(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .init_busy(busy0), .wr_conflict(conf0)
  );

  spu_regfile_mp #(.RD_REG(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .init_busy(busy1), .wr_conflict(conf1)
  );

  typedef struct {
    logic [1:0]   wen;
    logic [6:0]   wa0, wa1;
    logic [127:0] wd0, wd1;
    logic [1:0]   ren;
    logic [6:0]   ra0, ra1;
    logic [127:0] e0, e1;
    logic         ec;
  } vec_t;

  vec_t         vt [8];
  logic [127:0] mdl [128];
  logic [127:0] prev_exp [6];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic en, input logic [6:0] a, input logic [127:0] d);
    wr_en[p]            = en;
    wr_addr[p*7 +: 7]   = a;
    wr_data[p*128 +: 128] = d;
  endtask

  task automatic set_rd(input int p, input logic en, input logic [6:0] a);
    rd_en[p]          = en;
    rd_addr[p*7 +: 7] = a;
  endtask

  function automatic logic [127:0] rd0(input int p);
    return rd_data0[p*128 +: 128];
  endfunction

  function automatic logic [127:0] rd1(input int p);
    return rd_data1[p*128 +: 128];
  endfunction

  // Counts clock edges from the current point until init_busy drops (bounded).
  task automatic measure_busy(input string name);
    int n;
    n = 0;
    while (busy0 && n < 300) begin
      step();
      n++;
    end
    chk(name, 128'(n), 128'd128);
  endtask

  task automatic check_all_zero(input string name);
    wr_en = '0;
    for (int a = 0; a < 128; a += 6) begin
      for (int p = 0; p < 6; p++) set_rd(p, 1'b1, 7'((a + p) % 128));
      #1;
      for (int p = 0; p < 6; p++) chk(name, rd0(p), 128'd0);
    end
    rd_en = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p1, p2, pa, p5, p12, px, py, pz, ddead;
    logic [1:0]   rwen;
    logic [6:0]   rwa [2];
    logic [127:0] rwd [2];
    logic [5:0]   rren;
    logic [6:0]   rra [6];
    logic [127:0] ev;
    logic         ec;

    p1    = {8{16'h0001}};
    p2    = {8{16'h0002}};
    pa    = {8{16'hAAAA}};
    p5    = {8{16'h5555}};
    p12   = {8{16'h1234}};
    px    = {4{32'hCAFE_0003}};
    py    = {4{32'h0BAD_0020}};
    pz    = {4{32'hF00D_0021}};
    ddead = {4{32'hDEAD_BEEF}};

    vt[0] = '{wen:2'b11, wa0:7'd3,  wd0:p1,  wa1:7'd9,  wd1:p2, ren:2'b11, ra0:7'd3,  ra1:7'd9,  e0:p1,  e1:p2,  ec:1'b0};
    vt[1] = '{wen:2'b00, wa0:7'd3,  wd0:pa,  wa1:7'd9,  wd1:pa, ren:2'b11, ra0:7'd3,  ra1:7'd9,  e0:p1,  e1:p2,  ec:1'b0};
    vt[2] = '{wen:2'b11, wa0:7'd7,  wd0:pa,  wa1:7'd7,  wd1:p5, ren:2'b11, ra0:7'd7,  ra1:7'd7,  e0:p5,  e1:p5,  ec:1'b1};
    vt[3] = '{wen:2'b00, wa0:7'd7,  wd0:pa,  wa1:7'd7,  wd1:pa, ren:2'b01, ra0:7'd7,  ra1:7'd7,  e0:p5,  e1:'0,  ec:1'b0};
    vt[4] = '{wen:2'b01, wa0:7'd12, wd0:p12, wa1:7'd12, wd1:pa, ren:2'b11, ra0:7'd12, ra1:7'd13, e0:p12, e1:'0,  ec:1'b0};
    vt[5] = '{wen:2'b10, wa0:7'd3,  wd0:pa,  wa1:7'd3,  wd1:px, ren:2'b11, ra0:7'd3,  ra1:7'd9,  e0:px,  e1:p2,  ec:1'b0};
    vt[6] = '{wen:2'b11, wa0:7'd20, wd0:py,  wa1:7'd21, wd1:pz, ren:2'b11, ra0:7'd20, ra1:7'd21, e0:py,  e1:pz,  ec:1'b0};
    vt[7] = '{wen:2'b00, wa0:7'd20, wd0:pa,  wa1:7'd21, wd1:pa, ren:2'b11, ra0:7'd20, ra1:7'd21, e0:py,  e1:pz,  ec:1'b0};

    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '1; rd_addr = '0;
    repeat (3) step();
    chk("rst_busy", 128'(busy0), 128'd1);
    chk("rst_conflict", 128'(conf0), 128'd0);
    chk("rst_rdreg_data", rd1(0), 128'd0);

    // Write attempts to entry 5 during the whole clear must be ignored.
    set_wr(0, 1'b1, 7'd5, ddead);
    set_wr(1, 1'b1, 7'd5, ddead);
    set_rd(0, 1'b1, 7'd5);
    rst = 1'b0;
    #1;
    chk("clear_bypass_blocked", rd0(0), 128'd0);
    measure_busy("busy_len_first");
    chk("clear_conflict_held", 128'(conf0), 128'd0);
    chk("clear_rdreg_zero", rd1(0), 128'd0);
    check_all_zero("array_zero_after_clear");

    foreach (vt[v]) begin
      set_wr(0, vt[v].wen[0], vt[v].wa0, vt[v].wd0);
      set_wr(1, vt[v].wen[1], vt[v].wa1, vt[v].wd1);
      rd_en = '0;
      set_rd(0, vt[v].ren[0], vt[v].ra0);
      set_rd(1, vt[v].ren[1], vt[v].ra1);
      set_rd(5, 1'b0, vt[v].ra0);
      #1;
      chk($sformatf("vec%0d_comb_p0", v), rd0(0), vt[v].e0);
      chk($sformatf("vec%0d_comb_p1", v), rd0(1), vt[v].e1);
      chk($sformatf("vec%0d_disabled_p5", v), rd0(5), 128'd0);
      step();
      chk($sformatf("vec%0d_conflict", v), 128'(conf0), 128'(vt[v].ec));
      chk($sformatf("vec%0d_reg_p0", v), rd1(0), vt[v].e0);
      chk($sformatf("vec%0d_reg_p1", v), rd1(1), vt[v].e1);
    end
    wr_en = '0;
    step();
    chk("conflict_one_cycle", 128'(conf0), 128'd0);

    // Reset in the middle of a clear restarts the sequencer from entry 0.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (60) step();
    chk("midclear_busy", 128'(busy0), 128'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    measure_busy("busy_len_restart");
    chk("restart_busy_rdreg", 128'(busy1), 128'd0);
    check_all_zero("array_zero_after_restart");

    foreach (mdl[i]) mdl[i] = '0;
    foreach (prev_exp[i]) prev_exp[i] = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rwen = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        rwa[p] = (cyc % 8 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
        rwd[p] = {$urandom, $urandom, $urandom, $urandom};
        set_wr(p, rwen[p], rwa[p], rwd[p]);
      end
      rren = 6'($urandom_range(0, 63));
      for (int p = 0; p < 6; p++) begin
        rra[p] = (cyc % 8 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
        set_rd(p, rren[p], rra[p]);
      end
      #1;
      for (int p = 0; p < 6; p++) begin
        ev = '0;
        if (rren[p]) begin
          ev = mdl[rra[p]];
          if (rwen[0] && rwa[0] == rra[p]) ev = rwd[0];
          if (rwen[1] && rwa[1] == rra[p]) ev = rwd[1];
        end
        chk($sformatf("rand%0d_comb_p%0d", cyc, p), rd0(p), ev);
        prev_exp[p] = ev;
      end
      ec = rwen[0] && rwen[1] && (rwa[0] == rwa[1]);
      step();
      chk($sformatf("rand%0d_conflict", cyc), 128'(conf0), 128'(ec));
      for (int p = 0; p < 6; p++) chk($sformatf("rand%0d_reg_p%0d", cyc, p), rd1(p), prev_exp[p]);
      if (rwen[0]) mdl[rwa[0]] = rwd[0];
      if (rwen[1]) mdl[rwa[1]] = rwd[1];
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
